// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset vector and the fetch entry
// handed from the fetch queue to decode.
package cpu_pkg;

  localparam int          ADDR_W         = 16;
  localparam int          INSTR_W        = 16;
  localparam int          MEM_RD_LATENCY = 2;
  localparam logic [15:0] RESET_PC       = 16'h0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular buffer of fetch entries with a synchronous clear that wins over
// push/pop. The head is gated to zero while empty so nothing stale leaks out.
module sync_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: emptiness alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (int'(count_q) == DEPTH);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetcher: issues reads to a 2-cycle memory, tracks them
// in a two-stage return pipe and buffers results for decode.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                halt,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   flush_target,
  output logic [ADDR_W-2:0]   mem_raddr,
  input  logic [INSTR_W-1:0]  mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [ADDR_W-1:0]   out_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              v0_q, v0_d, v1_q, v1_d;
  logic [ADDR_W-1:0] p0_q, p0_d, p1_q, p1_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  fetch_entry_t      fifo_head, push_entry;
  logic              issue, push, pop;
  logic [1:0]        inflight;
  logic [CNT_W:0]    occupancy;

  // Entries queued plus reads still returning must never exceed DEPTH, so a
  // returning read always has a slot waiting for it.
  always_comb begin
    inflight   = {1'b0, v0_q} + {1'b0, v1_q};
    occupancy  = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
    issue      = !halt && !flush && (int'(occupancy) < DEPTH);
    push       = v1_q && !flush;
    pop        = !fifo_empty && out_ready && !flush;
    push_entry = '{instr: mem_rdata, pc: p1_q};
  end

  always_comb begin
    pc_d = pc_q;
    v0_d = issue;
    p0_d = pc_q;
    v1_d = v0_q && !flush;
    p1_d = p0_q;
    if (flush)      pc_d = flush_target & 16'hFFFE;
    else if (issue) pc_d = pc_q + 16'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      p0_q <= '0;
      p1_q <= '0;
    end else begin
      pc_q <= pc_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
      p0_q <= p0_d;
      p1_q <= p1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) assert (!fifo_full);
  end

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign mem_raddr = pc_q[ADDR_W-1:1];
  assign out_valid = !fifo_empty;
  assign out_instr = fifo_head.instr;
  assign out_pc    = fifo_head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scoreboard queue of expected entries is
// filled by the stimulus and drained by an independent handshake monitor.
module tb_fetch_queue;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, halt, flush, out_ready, out_valid;
  logic [15:0] flush_target, mem_rdata, out_instr, out_pc;
  logic [14:0] mem_raddr;
  logic [15:0] rd_stage;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  fetch_entry_t exp_q[$];

  fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .halt         (halt),
    .flush        (flush),
    .flush_target (flush_target),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc)
  );

  always #5 clk = ~clk;

  // Memory word k holds 16'h8000 | k, returned two cycles after the address.
  always @(posedge clk) begin
    rd_stage  <= 16'h8000 | {1'b0, mem_raddr};
    mem_rdata <= rd_stage;
  end

  function automatic logic [15:0] word_at(input logic [15:0] pc);
    return 16'h8000 | {1'b0, pc[15:1]};
  endfunction

  task automatic set_stream(input logic [15:0] start);
    logic [15:0] p;
    fetch_entry_t e;
    p = start & 16'hFFFE;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      e.pc    = p;
      e.instr = word_at(p);
      exp_q.push_back(e);
      p = p + 16'd2;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic wait_first_valid(input string name, input int want_edges);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n, want_edges);
  endtask

  // Monitor: every accepted head must match the front of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      fetch_entry_t e;
      total++;
      pops++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream: unexpected pc=%h instr=%h", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          bad++;
          $display("FAIL stream: got pc=%h instr=%h want pc=%h instr=%h",
                   out_pc, out_instr, e.pc, e.instr);
        end else begin
          $display("pop  pc=%h instr=%h", out_pc, out_instr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] t;
    rst_n = 1'b0; halt = 1'b0; flush = 1'b0; flush_target = '0; out_ready = 1'b1;
    set_stream(16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", {31'b0, out_valid}, 0);
    check("reset out_pc", {16'b0, out_pc}, 0);
    check("reset out_instr", {16'b0, out_instr}, 0);
    check("reset mem_raddr", {17'b0, mem_raddr}, 0);

    rst_n = 1'b1;
    wait_first_valid("reset latency", 3);
    repeat (8) @(posedge clk);
    #1;

    // Backpressure: the queue fills to 4 and pc freezes 4 entries past the head.
    out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    t = exp_q[0].pc + 16'd8;
    check("full pc frozen", {17'b0, mem_raddr}, {17'b0, t[15:1]});
    check("full out_valid", {31'b0, out_valid}, 1);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Flush while reads are in flight; out_ready high so the handshake is void.
    flush = 1'b1; flush_target = 16'h0041;
    set_stream(16'h0040);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush empties queue", {31'b0, out_valid}, 0);
    check("flush raddr", {17'b0, mem_raddr}, 32'h20);
    begin
      int n;
      n = 1;
      while (!out_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("flush latency", n, 4);
    end
    repeat (6) @(posedge clk);
    #1;

    // Halt: in-flight reads land, queue drains, pc holds at the next expected.
    halt = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("halt drained", {31'b0, out_valid}, 0);
    t = exp_q[0].pc;
    check("halt pc held", {17'b0, mem_raddr}, {17'b0, t[15:1]});
    halt = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Address wrap.
    flush = 1'b1; flush_target = 16'hFFFC;
    set_stream(16'hFFFC);
    @(posedge clk); #1;
    flush = 1'b0;
    check("wrap empties queue", {31'b0, out_valid}, 0);
    wait_first_valid("wrap latency", 3);
    repeat (8) @(posedge clk);
    #1;

    // Asynchronous reset between edges with queue loaded and reads returning.
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("pre-reset out_valid", {31'b0, out_valid}, 1);
    rst_n = 1'b0;
    set_stream(16'h0000);
    #1;
    check("async reset out_valid", {31'b0, out_valid}, 0);
    check("async reset raddr", {17'b0, mem_raddr}, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    rst_n = 1'b1;
    wait_first_valid("restart latency", 3);
    repeat (8) @(posedge clk);
    #1;

    check("handshakes seen", {31'b0, pops >= 40}, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
